// File: rtl/toy_pack.sv
// Shared defaults, recovery FSM encoding and width helpers for the
// physical-register status generator.
package toy_pack;

    localparam int DEF_INST_DECODE_NUM = 4;
    localparam int DEF_EU_NUM          = 4;
    localparam int DEF_PHY_REG_NUM     = 64;
    localparam int DEF_ARCH_REG_NUM    = 32;
    localparam int DEF_SRC_NUM         = 3;
    localparam int DEF_RECOVER_CYC     = 2;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } rec_state_e;

    // Index width that stays at least one bit wide for single-entry sets.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ID_W  = idx_width(DEF_PHY_REG_NUM);
    localparam int DEF_FID_W = idx_width(DEF_EU_NUM);

endpackage

// File: rtl/toy_phy_free_pick.sv
// Find-first-N picker: offers the ALLOC_NUM lowest set bits of a free bitmap,
// lane i carrying the i-th lowest free index.
module toy_phy_free_pick #(
    parameter int PHY_REG_NUM = 64,
    parameter int ALLOC_NUM   = 4,
    parameter int ID_W        = 6
) (
    input  logic [PHY_REG_NUM-1:0]    i_bitmap,
    output logic [ALLOC_NUM*ID_W-1:0] o_id,
    output logic [ALLOC_NUM-1:0]      o_vld
);

    always_comb begin : pick
        int n;
        n     = 0;
        o_id  = '0;
        o_vld = '0;
        for (int r = 0; r < PHY_REG_NUM; r++) begin
            if (i_bitmap[r] && (n < ALLOC_NUM)) begin
                o_id[n*ID_W +: ID_W] = ID_W'(r);
                o_vld[n]             = 1'b1;
                n                    = n + 1;
            end
        end
    end

endmodule

// File: rtl/toy_phy_reg_status_gen.sv
// Physical register free-list and ready-table for one register class, with
// writeback bypass, forward-hit detection and cancel recovery.
module toy_phy_reg_status_gen
    import toy_pack::*;
#(
    parameter  int PHY_REG_NUM  = DEF_PHY_REG_NUM,
    parameter  int ARCH_REG_NUM = DEF_ARCH_REG_NUM,
    parameter  int ALLOC_NUM    = DEF_INST_DECODE_NUM,
    parameter  int WB_NUM       = DEF_EU_NUM,
    parameter  int SRC_NUM      = DEF_SRC_NUM,
    parameter  int ZERO_REG_EN  = 1,
    parameter  int RECOVER_CYC  = DEF_RECOVER_CYC,
    localparam int ID_W         = idx_width(PHY_REG_NUM),
    localparam int FID_W        = idx_width(WB_NUM),
    localparam int NSRC         = ALLOC_NUM * SRC_NUM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WB_NUM-1:0]         wb_en,
    input  logic [WB_NUM*ID_W-1:0]    wb_idx,
    input  logic [WB_NUM-1:0]         fwd_en,
    input  logic [WB_NUM*ID_W-1:0]    fwd_idx,
    input  logic [ALLOC_NUM-1:0]      alloc_rdy,
    output logic [ALLOC_NUM-1:0]      alloc_vld,
    output logic [ALLOC_NUM*ID_W-1:0] alloc_id,
    input  logic [NSRC*ID_W-1:0]      src_idx,
    output logic [NSRC-1:0]           src_rdy,
    output logic [NSRC*WB_NUM-1:0]    src_fwd,
    output logic [NSRC*FID_W-1:0]     src_fwd_id,
    input  logic [PHY_REG_NUM-1:0]    reg_release,
    input  logic [PHY_REG_NUM-1:0]    back_ref,
    input  logic                      cancel_en,
    output logic [ID_W:0]             free_cnt,
    output logic                      recover_busy
);

    localparam int CNT_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
    localparam logic [PHY_REG_NUM-1:0] ZERO_BIT =
        (ZERO_REG_EN != 0) ? {{(PHY_REG_NUM-1){1'b0}}, 1'b1} : '0;

    function automatic logic [PHY_REG_NUM-1:0] reset_free();
        logic [PHY_REG_NUM-1:0] m;
        m = '0;
        for (int r = ARCH_REG_NUM; r < PHY_REG_NUM; r++) m[r] = 1'b1;
        return m & ~ZERO_BIT;
    endfunction

    localparam logic [PHY_REG_NUM-1:0] RST_FREE = reset_free();

    logic [PHY_REG_NUM-1:0]    r_free;
    logic [PHY_REG_NUM-1:0]    r_rdy;
    rec_state_e                r_state;
    logic [CNT_W-1:0]          r_rec_cnt;
    logic [ID_W:0]             r_free_cnt;

    logic [ALLOC_NUM*ID_W-1:0] w_pick_id;
    logic [ALLOC_NUM-1:0]      w_pick_vld;
    logic                      w_run;
    logic [ALLOC_NUM-1:0]      w_fire;
    logic [PHY_REG_NUM-1:0]    w_fire_mask;
    logic [PHY_REG_NUM-1:0]    w_wb_mask;
    logic [PHY_REG_NUM-1:0]    w_free_nxt;
    logic [PHY_REG_NUM-1:0]    w_rdy_nxt;
    logic [ID_W:0]             w_free_pop;

    toy_phy_free_pick #(
        .PHY_REG_NUM (PHY_REG_NUM),
        .ALLOC_NUM   (ALLOC_NUM),
        .ID_W        (ID_W)
    ) u_pick (
        .i_bitmap (r_free),
        .o_id     (w_pick_id),
        .o_vld    (w_pick_vld)
    );

    assign w_run     = (r_state == ST_RUN);
    assign alloc_id  = w_pick_id;
    assign alloc_vld = w_pick_vld & {ALLOC_NUM{w_run & ~cancel_en}};
    assign w_fire    = alloc_vld & alloc_rdy;

    always_comb begin
        w_fire_mask = '0;
        for (int i = 0; i < ALLOC_NUM; i++) begin
            if (w_fire[i]) w_fire_mask[alloc_id[i*ID_W +: ID_W]] = 1'b1;
        end
    end

    // Writebacks are dropped while recovering; the same mask feeds the bypass.
    always_comb begin
        w_wb_mask = '0;
        for (int j = 0; j < WB_NUM; j++) begin
            if (wb_en[j] && w_run) w_wb_mask[wb_idx[j*ID_W +: ID_W]] = 1'b1;
        end
    end

    always_comb begin
        w_free_nxt = r_free;
        w_rdy_nxt  = r_rdy;
        if (cancel_en) begin
            w_free_nxt = ~back_ref & ~ZERO_BIT;
            w_rdy_nxt  = '1;
        end else if (w_run) begin
            w_free_nxt = (r_free | (reg_release & ~ZERO_BIT)) & ~w_fire_mask;
            w_rdy_nxt  = (r_rdy | w_wb_mask | ZERO_BIT) & ~w_fire_mask;
        end
    end

    always_comb begin
        w_free_pop = '0;
        for (int r = 0; r < PHY_REG_NUM; r++) begin
            w_free_pop = w_free_pop + (ID_W+1)'(w_free_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free     <= RST_FREE;
            r_rdy      <= '1;
            r_free_cnt <= (ID_W+1)'(PHY_REG_NUM - ARCH_REG_NUM);
        end else begin
            r_free     <= w_free_nxt;
            r_rdy      <= w_rdy_nxt;
            r_free_cnt <= w_free_pop;
        end
    end

    // A cancel arriving mid-recovery reloads the counter and extends the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_rec_cnt <= '0;
        end else if (cancel_en) begin
            r_state   <= ST_RECOVER;
            r_rec_cnt <= CNT_W'(RECOVER_CYC - 1);
        end else if (r_state == ST_RECOVER) begin
            if (r_rec_cnt == '0) r_state <= ST_RUN;
            else                 r_rec_cnt <= r_rec_cnt - 1'b1;
        end
    end

    always_comb begin
        src_rdy    = '0;
        src_fwd    = '0;
        src_fwd_id = '0;
        for (int k = 0; k < NSRC; k++) begin : lookup
            logic [ID_W-1:0] idx;
            logic            is_zero;
            logic            found;
            idx     = src_idx[k*ID_W +: ID_W];
            is_zero = (ZERO_REG_EN != 0) && (idx == '0);
            found   = 1'b0;
            src_rdy[k] = r_rdy[idx] | w_wb_mask[idx] | is_zero;
            for (int j = 0; j < WB_NUM; j++) begin
                if (fwd_en[j] && (fwd_idx[j*ID_W +: ID_W] == idx) && !is_zero) begin
                    src_fwd[k*WB_NUM + j] = 1'b1;
                    if (!found) begin
                        src_fwd_id[k*FID_W +: FID_W] = FID_W'(j);
                        found = 1'b1;
                    end
                end
            end
        end
    end

    assign free_cnt     = r_free_cnt;
    assign recover_busy = (r_state == ST_RECOVER);

endmodule

// File: tb/tb_toy_phy_reg_status_gen.sv
// Directed bench for toy_phy_reg_status_gen: stimulus queues expected outputs
// per cycle, a monitor compares them on the falling edge.
module tb_toy_phy_reg_status_gen;
    import toy_pack::*;

    localparam int IW = 6;
    localparam int NA = 4;
    localparam int NW = 4;
    localparam int NS = 12;
    localparam int FW = 2;

    localparam int K_VLD  = 0;
    localparam int K_ID   = 1;
    localparam int K_CNT  = 2;
    localparam int K_BUSY = 3;
    localparam int K_SRDY = 4;
    localparam int K_SFWD = 5;
    localparam int K_SFID = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NW-1:0]     wb_en = '0;
    logic [NW*IW-1:0]  wb_idx = '0;
    logic [NW-1:0]     fwd_en = '0;
    logic [NW*IW-1:0]  fwd_idx = '0;
    logic [NA-1:0]     alloc_rdy = '0;
    logic [NA-1:0]     alloc_vld;
    logic [NA*IW-1:0]  alloc_id;
    logic [NS*IW-1:0]  src_idx = '0;
    logic [NS-1:0]     src_rdy;
    logic [NS*NW-1:0]  src_fwd;
    logic [NS*FW-1:0]  src_fwd_id;
    logic [63:0]       reg_release = '0;
    logic [63:0]       back_ref = '0;
    logic              cancel_en = 1'b0;
    logic [IW:0]       free_cnt;
    logic              recover_busy;

    toy_phy_reg_status_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_en        (wb_en),
        .wb_idx       (wb_idx),
        .fwd_en       (fwd_en),
        .fwd_idx      (fwd_idx),
        .alloc_rdy    (alloc_rdy),
        .alloc_vld    (alloc_vld),
        .alloc_id     (alloc_id),
        .src_idx      (src_idx),
        .src_rdy      (src_rdy),
        .src_fwd      (src_fwd),
        .src_fwd_id   (src_fwd_id),
        .reg_release  (reg_release),
        .back_ref     (back_ref),
        .cancel_en    (cancel_en),
        .free_cnt     (free_cnt),
        .recover_busy (recover_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          what;
        int          idx;
        logic [63:0] val;
    } chk_t;

    chk_t  sbq[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    string names [7] = '{"alloc_vld", "alloc_id", "free_cnt", "recover_busy",
                         "src_rdy", "src_fwd", "src_fwd_id"};

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic logic [63:0] actual(input int what, input int idx);
        case (what)
            K_VLD:   return 64'(alloc_vld);
            K_ID:    return 64'(alloc_id[idx*IW +: IW]);
            K_CNT:   return 64'(free_cnt);
            K_BUSY:  return 64'(recover_busy);
            K_SRDY:  return 64'(src_rdy[idx]);
            K_SFWD:  return 64'(src_fwd[idx*NW +: NW]);
            default: return 64'(src_fwd_id[idx*FW +: FW]);
        endcase
    endfunction

    initial forever begin : monitor
        chk_t        c;
        logic [63:0] a;
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            c = sbq.pop_front();
            a = actual(c.what, c.idx);
            n_cmp = n_cmp + 1;
            if (a !== c.val) begin
                n_bad = n_bad + 1;
                $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d",
                         names[c.what], c.idx, c.cyc, a, c.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        alloc_rdy   = '0;
        wb_en       = '0;
        wb_idx      = '0;
        fwd_en      = '0;
        fwd_idx     = '0;
        src_idx     = '0;
        reg_release = '0;
        cancel_en   = 1'b0;
    endtask

    task automatic ex(input int what, input int idx, input logic [63:0] v);
        chk_t c;
        c.cyc  = cyc;
        c.what = what;
        c.idx  = idx;
        c.val  = v;
        sbq.push_back(c);
    endtask

    task automatic ex_ids(input int base, input int n);
        for (int i = 0; i < n; i++) ex(K_ID, i, 64'(base + i));
    endtask

    task automatic set_src(input int k, input int v);
        src_idx[k*IW +: IW] = IW'(v);
    endtask

    task automatic set_wb(input int j, input int v);
        wb_idx[j*IW +: IW] = IW'(v);
    endtask

    task automatic set_fwd(input int j, input int v);
        fwd_idx[j*IW +: IW] = IW'(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        step();
        ex(K_CNT, 0, 32); ex(K_BUSY, 0, 0);
        step(); rst_n = 1'b1;
        ex(K_VLD, 0, 4'hF); ex_ids(32, 4); ex(K_CNT, 0, 32); ex(K_BUSY, 0, 0);
        // fire lanes 0,1
        step(); alloc_rdy = 4'b0011;
        ex_ids(32, 4);
        step(); alloc_rdy = 4'hF;
        ex_ids(34, 4); ex(K_CNT, 0, 30);
        set_src(0, 32); ex(K_SRDY, 0, 0);
        set_src(1, 0);  ex(K_SRDY, 1, 1);
        set_src(2, 36); ex(K_SRDY, 2, 1);
        step(); alloc_rdy = 4'hF;
        ex_ids(38, 4); ex(K_CNT, 0, 26);
        // p40 allocated, not yet written back
        step();
        set_src(0, 40); ex(K_SRDY, 0, 0); ex(K_CNT, 0, 22); ex(K_ID, 0, 42);
        // writeback p40 (bypass) and p42 while p42 is being allocated
        step(); wb_en = 4'b0011; set_wb(0, 40); set_wb(1, 42); alloc_rdy = 4'b0001;
        set_src(0, 40); ex(K_SRDY, 0, 1); ex(K_ID, 0, 42);
        step();
        set_src(0, 40); ex(K_SRDY, 0, 1);
        set_src(1, 42); ex(K_SRDY, 1, 0);
        ex(K_CNT, 0, 21); ex(K_ID, 0, 43);
        // forward hits
        step(); fwd_en = 4'b0111; set_fwd(0, 0); set_fwd(1, 45); set_fwd(2, 45);
        set_src(2, 45); set_src(3, 46); set_src(4, 0);
        ex(K_SFWD, 2, 4'b0110); ex(K_SFID, 2, 1);
        ex(K_SFWD, 3, 0);       ex(K_SFID, 3, 0);
        ex(K_SFWD, 4, 0);
        // drain down to two free
        step(); alloc_rdy = 4'hF; ex(K_CNT, 0, 21); ex(K_ID, 0, 43);
        step(); alloc_rdy = 4'hF; ex(K_CNT, 0, 17); ex(K_ID, 0, 47);
        step(); alloc_rdy = 4'hF; ex(K_CNT, 0, 13); ex(K_ID, 0, 51);
        step(); alloc_rdy = 4'hF; ex(K_CNT, 0, 9);  ex(K_ID, 0, 55);
        step(); alloc_rdy = 4'b0111; ex(K_CNT, 0, 5); ex_ids(59, 4);
        step(); alloc_rdy = 4'b0001; reg_release[5] = 1'b1;
        ex(K_VLD, 0, 4'b0011); ex_ids(62, 2); ex(K_CNT, 0, 2);
        step(); alloc_rdy = 4'b0011; reg_release[63] = 1'b1;
        ex(K_VLD, 0, 4'b0011); ex(K_ID, 0, 5); ex(K_ID, 1, 63); ex(K_CNT, 0, 2);
        step();
        ex(K_CNT, 0, 0); ex(K_VLD, 0, 0);
        // cancel and recovery
        step(); cancel_en = 1'b1; back_ref = 64'h0000_0000_FFFF_FFFF;
        ex(K_VLD, 0, 0); ex(K_BUSY, 0, 0);
        step(); ex(K_BUSY, 0, 1); ex(K_VLD, 0, 0); ex(K_CNT, 0, 32);
        step(); reg_release[10] = 1'b1;
        ex(K_BUSY, 0, 1); ex(K_VLD, 0, 0);
        step(); ex(K_BUSY, 0, 0); ex(K_VLD, 0, 4'hF); ex(K_ID, 0, 32); ex(K_CNT, 0, 32);
        // cancel again during recovery restarts the count
        step(); cancel_en = 1'b1; back_ref = 64'h0000_0001_FFFF_FFFF;
        step(); cancel_en = 1'b1; ex(K_BUSY, 0, 1);
        step(); ex(K_BUSY, 0, 1);
        step(); ex(K_BUSY, 0, 1); ex(K_VLD, 0, 0);
        step(); ex(K_BUSY, 0, 0); ex(K_CNT, 0, 31); ex(K_ID, 0, 33);
        // zero register survives release and cancel reload
        step(); cancel_en = 1'b1; back_ref = 64'h0000_0000_FFFF_FFFE; reg_release[0] = 1'b1;
        step(); ex(K_BUSY, 0, 1); ex(K_CNT, 0, 32);
        step(); ex(K_BUSY, 0, 1);
        step(); reg_release[0] = 1'b1; set_src(0, 0);
        ex(K_BUSY, 0, 0); ex(K_CNT, 0, 32); ex(K_ID, 0, 32); ex(K_SRDY, 0, 1);
        step(); ex(K_CNT, 0, 32); ex(K_ID, 0, 32);
        // reset while recovering
        step(); cancel_en = 1'b1; back_ref = 64'h0;
        step(); rst_n = 1'b0;
        ex(K_CNT, 0, 32); ex(K_BUSY, 0, 0);
        step(); rst_n = 1'b1;
        ex(K_VLD, 0, 4'hF); ex_ids(32, 4); ex(K_CNT, 0, 32); ex(K_BUSY, 0, 0);
        step();
        step();
        n_cmp = n_cmp + 1;
        if (sbq.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
